car_sync_tx: RTL and testbench

- Transmit side of the two-board car-state link.
- Snapshots the local physics engine's collision-box centres, angle, lap flag, finish and game state at a fixed frame rate.
- Packs the snapshot into a 9-byte checksummed frame and sends it 8N1 over a single serial line.
- The peer board's receiver turns the frame back into its other_f_x/other_f_y/other_r_x/other_r_y inputs.

---
 rtl/car_link_pkg.sv | 76 +++++++
 rtl/car_sync_tx_if.sv | 30 +++
 rtl/uart_tx_byte.sv | 88 ++++++++
 rtl/car_sync_tx.sv | 152 +++++++++++++++
 tb/tb_car_sync_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/car_link_pkg.sv
// Shared definitions for the two-board car-state link (tx and rx sides).
// Frame: 9 bytes, sent 8N1 with byte 0 first.
//   b0     sync byte 0xA5
//   b1     {seq[4:0], state[2:0]}
//   b2..b6 {f_x, f_y, r_x, r_y}, 40 bits, MSB first
//   b7     {angle_idx, flag, finish, 1'b0}
//   b8     XOR of b1..b7
package car_link_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned FRAME_BYTES = 9;

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_SETTING   = 3'd1,
    GS_SYNCING   = 3'd2,
    GS_COUNTDOWN = 3'd3,
    GS_RACING    = 3'd4,
    GS_PAUSE     = 3'd5,
    GS_FINISH    = 3'd6
  } game_state_t;

  // Byte offsets within a frame
  localparam logic [3:0] B_SYNC      = 4'd0;
  localparam logic [3:0] B_HDR       = 4'd1;
  localparam logic [3:0] B_POS_FIRST = 4'd2;
  localparam logic [3:0] B_POS_LAST  = 4'd6;
  localparam logic [3:0] B_AUX       = 4'd7;
  localparam logic [3:0] B_CSUM      = 4'(FRAME_BYTES - 1);

  typedef struct packed {
    logic [4:0] seq;
    logic [2:0] state;
    logic [9:0] f_x;
    logic [9:0] f_y;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [3:0] angle_idx;
    logic [1:0] flag;
    logic       finish;
  } car_snap_t;

  // Bytes 0..7 (everything except the checksum)
  function automatic logic [7:0] payload_byte(car_snap_t s, logic [3:0] idx);
    logic [39:0] pos;
    logic [7:0]  b;
    pos = {s.f_x, s.f_y, s.r_x, s.r_y};
    b   = '0;
    case (idx)
      B_SYNC:      b = SYNC_BYTE;
      B_HDR:       b = {s.seq, s.state};
      B_POS_FIRST: b = pos[39:32];
      4'd3:        b = pos[31:24];
      4'd4:        b = pos[23:16];
      4'd5:        b = pos[15:8];
      B_POS_LAST:  b = pos[7:0];
      B_AUX:       b = {s.angle_idx, s.flag, s.finish, 1'b0};
      default:     b = '0;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] frame_byte(car_snap_t s, logic [3:0] idx);
    logic [7:0] c;
    c = '0;
    if (idx == B_CSUM) begin
      for (int unsigned i = 32'(B_HDR); i <= 32'(B_AUX); i++) begin
        c ^= payload_byte(s, i[3:0]);
      end
    end else begin
      c = payload_byte(s, idx);
    end
    return c;
  endfunction

endpackage

// File: rtl/car_sync_tx_if.sv
// Car-state link transmit bundle.
//   enable, state, my_f_x/my_f_y/my_r_x/my_r_y, angle_idx, flag, finish : snapshot sources
//   tx, busy, frame_done, seq, overrun_cnt                              : transmitter status
// master = physics/game side, slave = car_sync_tx.
interface car_sync_tx_if;
  logic       enable;
  logic [2:0] state;
  logic [9:0] my_f_x;
  logic [9:0] my_f_y;
  logic [9:0] my_r_x;
  logic [9:0] my_r_y;
  logic [3:0] angle_idx;
  logic [1:0] flag;
  logic       finish;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [4:0] seq;
  logic [7:0] overrun_cnt;

  modport master (
    output enable, state, my_f_x, my_f_y, my_r_x, my_r_y, angle_idx, flag, finish,
    input  tx, busy, frame_done, seq, overrun_cnt
  );

  modport slave (
    input  enable, state, my_f_x, my_f_y, my_r_x, my_r_y, angle_idx, flag, finish,
    output tx, busy, frame_done, seq, overrun_cnt
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit,
// each BAUD_DIV clk cycles long.
//   clk, rst : clock, synchronous active-high reset
//   start    : load data and begin a byte (honoured only while ready)
//   data     : byte to send
//   tx       : serial line, idle high
//   ready    : idle, or in the final cycle of the stop bit; a start in that
//              cycle chains the next byte with no idle gap
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned   BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

  ustate_t       st, st_n;
  logic [BW-1:0] tmr, tmr_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          bit_end;

  assign bit_end = (tmr == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= U_IDLE;
      tmr     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      st      <= st_n;
      tmr     <= tmr_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    st_n      = st;
    tmr_n     = tmr;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx        = 1'b1;
    ready     = (st == U_IDLE) || ((st == U_STOP) && bit_end);

    if (st != U_IDLE) tmr_n = bit_end ? '0 : tmr + 1'b1;

    case (st)
      U_START: begin
        tx = 1'b0;
        if (bit_end) begin
          st_n      = U_DATA;
          bit_idx_n = '0;
        end
      end
      U_DATA: begin
        tx = shreg[0];
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_idx == 3'd7) st_n = U_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      U_STOP: begin
        tx = 1'b1;
        if (bit_end) st_n = U_IDLE;
      end
      default: ;
    endcase

    if (start && ready) begin
      st_n      = U_START;
      tmr_n     = '0;
      bit_idx_n = '0;
      shreg_n   = data;
    end
  end

endmodule

// File: rtl/car_sync_tx.sv
// Transmit side of the two-board car-state link. At each frame tick the
// local car state is snapshotted and sent as one 9-byte checksummed frame.
//   clk, rst : clock, synchronous active-high reset
//   bus      : car_sync_tx_if.slave
//     enable                            permits new frames to start
//     state, my_*, angle_idx, flag, finish  snapshot sources
//     tx          serial line (8N1), idle high
//     busy        frame in flight
//     frame_done  one-cycle pulse after the last stop bit
//     seq         sequence number carried by the next frame
//     overrun_cnt saturating count of dropped frame ticks
module car_sync_tx
  import car_link_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned FRAME_HZ = 120
) (
  input logic          clk,
  input logic          rst,
  car_sync_tx_if.slave bus
);

  localparam int unsigned   BAUD_DIV   = CLK_FREQ / BAUD;
  localparam int unsigned   FRAME_DIV  = CLK_FREQ / FRAME_HZ;
  localparam int unsigned   FW         = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {F_IDLE, F_SEND, F_DONE} fstate_t;

  fstate_t       fst, fst_n;
  logic [FW-1:0] frame_tmr, tmr_n;
  logic          pending, pending_n;
  logic [7:0]    overrun, overrun_n;
  logic [4:0]    seq, seq_n;
  logic [3:0]    byte_idx, byte_idx_n;
  car_snap_t     snap, snap_n;

  logic          tick;
  logic          start_frame;
  logic          frame_done;
  logic          uart_start;
  logic          uart_ready;
  logic [7:0]    uart_data;

  assign tick = bus.enable && (frame_tmr == FRAME_LAST);

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (uart_start),
    .data  (uart_data),
    .tx    (bus.tx),
    .ready (uart_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fst       <= F_IDLE;
      frame_tmr <= '0;
      pending   <= 1'b0;
      overrun   <= '0;
      seq       <= '0;
      byte_idx  <= '0;
      snap      <= '0;
    end else begin
      fst       <= fst_n;
      frame_tmr <= tmr_n;
      pending   <= pending_n;
      overrun   <= overrun_n;
      seq       <= seq_n;
      byte_idx  <= byte_idx_n;
      snap      <= snap_n;
    end
  end

  always_comb begin
    fst_n      = fst;
    pending_n  = pending;
    overrun_n  = overrun;
    seq_n      = seq;
    byte_idx_n = byte_idx;
    snap_n     = snap;
    uart_start = 1'b0;
    uart_data  = SYNC_BYTE;
    frame_done = 1'b0;

    tmr_n = (!bus.enable || tick) ? '0 : frame_tmr + 1'b1;

    // seq has already advanced when leaving DONE, so a chained frame
    // snapshots the new number.
    start_frame = bus.enable &&
                  (((fst == F_IDLE) && (tick || pending)) ||
                   ((fst == F_DONE) && pending));

    // In IDLE any start absorbs the pending request; when DONE chains a
    // pending frame, a tick arriving in that same cycle becomes the new pending.
    if (!bus.enable) begin
      pending_n = 1'b0;
    end else if (fst == F_IDLE) begin
      pending_n = 1'b0;
    end else if (start_frame) begin
      pending_n = tick;
    end else if (tick) begin
      if (pending) overrun_n = (overrun == '1) ? overrun : overrun + 8'd1;
      else         pending_n = 1'b1;
    end

    case (fst)
      F_SEND: begin
        if (uart_ready) begin
          if (byte_idx < B_CSUM) begin
            uart_start = 1'b1;
            uart_data  = frame_byte(snap, byte_idx + 4'd1);
            byte_idx_n = byte_idx + 4'd1;
          end else begin
            fst_n = F_DONE;
            seq_n = seq + 5'd1;
          end
        end
      end
      F_DONE: begin
        frame_done = 1'b1;
        fst_n      = F_IDLE;
      end
      default: ;
    endcase

    // Sync byte is constant, so it can go out on the same edge as the snapshot.
    if (start_frame) begin
      fst_n      = F_SEND;
      byte_idx_n = '0;
      uart_start = 1'b1;
      uart_data  = SYNC_BYTE;
      snap_n     = '{seq:       seq,
                     state:     bus.state,
                     f_x:       bus.my_f_x,
                     f_y:       bus.my_f_y,
                     r_x:       bus.my_r_x,
                     r_y:       bus.my_r_y,
                     angle_idx: bus.angle_idx,
                     flag:      bus.flag,
                     finish:    bus.finish};
    end
  end

  assign bus.busy        = (fst == F_SEND);
  assign bus.frame_done  = frame_done;
  assign bus.seq         = seq;
  assign bus.overrun_cnt = overrun;

endmodule

// File: tb/tb_car_sync_tx.sv
module tb_car_sync_tx;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   sel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  car_sync_tx_if m_if ();
  car_sync_tx_if o_if ();

  // BAUD_DIV=16, FRAME_DIV=1600
  car_sync_tx #(.CLK_FREQ(1600), .BAUD(100), .FRAME_HZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  // BAUD_DIV=16, FRAME_DIV=100: ticks much faster than frames
  car_sync_tx #(.CLK_FREQ(1600), .BAUD(100), .FRAME_HZ(16)) dut_ov (
    .clk (clk),
    .rst (rst),
    .bus (o_if.slave)
  );

  logic       ser, l_busy, l_done;
  logic [4:0] l_seq;
  always_comb begin
    ser    = sel ? o_if.tx         : m_if.tx;
    l_busy = sel ? o_if.busy       : m_if.busy;
    l_done = sel ? o_if.frame_done : m_if.frame_done;
    l_seq  = sel ? o_if.seq        : m_if.seq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes listed in transmission order, b0 leftmost
  function automatic logic [8:0][7:0] fr(input logic [71:0] v);
    logic [8:0][7:0] r;
    for (int k = 0; k < 9; k++) r[k] = v[71 - 8*k -: 8];
    return r;
  endfunction

  task automatic cmp_frame(input string tag, input logic [8:0][7:0] got, input logic [8:0][7:0] exp);
    for (int k = 0; k < 9; k++) check($sformatf("%s_b%0d", tag, k), {24'd0, got[k]}, {24'd0, exp[k]});
  endtask

  task automatic wait_start(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ser === 1'b0) begin
        t = cyc;
        break;
      end
    end
    check("start_seen", {31'd0, t >= 0}, 32'd1);
  endtask

  // Entered at the negedge of the first start-bit cycle (offset 0); samples
  // every bit mid-way and returns at offset 1440 (frame_done cycle).
  task automatic get_frame(output logic [8:0][7:0] b, input int mod_kind, input int mod_byte,
                           input bit probe);
    int pos, o, ferr;
    logic [9:0] bits;
    pos = 0;
    ferr = 0;
    b = '0;
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 10; j++) begin
        o = k*160 + j*16 + 8;
        repeat (o - pos) @(negedge clk);
        pos = o;
        bits[j] = ser;
        if (k == mod_byte && j == 0) begin
          if (mod_kind == 1) m_if.my_f_x = 10'd200;
          if (mod_kind == 2) o_if.enable = 1'b0;
        end
        if (probe && k == 1 && j == 0) begin
          check("ovr_after_pending", {24'd0, o_if.overrun_cnt}, 32'd0);
          check("busy_mid", {31'd0, l_busy}, 32'd1);
        end
        if (probe && k == 1 && j == 5) check("ovr_third_tick", {24'd0, o_if.overrun_cnt}, 32'd1);
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ferr++;
      b[k] = bits[8:1];
    end
    check("framing", ferr, 0);
    repeat (1439 - pos) @(negedge clk);
    check("busy_last", {31'd0, l_busy}, 32'd1);
    check("done_early", {31'd0, l_done}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, l_done}, 32'd1);
    check("busy_end", {31'd0, l_busy}, 32'd0);
  endtask

  initial begin
    logic [8:0][7:0] got;
    logic [7:0] x;
    int t, t0, r, idle_err;

    sel = 1'b0;
    rst = 1'b1;
    m_if.enable = 0; m_if.state = 3'd4; m_if.my_f_x = 10'd100; m_if.my_f_y = 10'd50;
    m_if.my_r_x = 10'd96; m_if.my_r_y = 10'd50; m_if.angle_idx = 4'd4; m_if.flag = 2'd2;
    m_if.finish = 0;
    o_if.enable = 0; o_if.state = 3'd4; o_if.my_f_x = 10'd100; o_if.my_f_y = 10'd50;
    o_if.my_r_x = 10'd96; o_if.my_r_y = 10'd50; o_if.angle_idx = 4'd4; o_if.flag = 2'd2;
    o_if.finish = 0;
    repeat (4) @(negedge clk);
    check("rst_tx", {31'd0, m_if.tx}, 32'd1);
    check("rst_busy", {31'd0, m_if.busy}, 32'd0);
    check("rst_done", {31'd0, m_if.frame_done}, 32'd0);
    check("rst_seq", {27'd0, m_if.seq}, 32'd0);
    check("rst_ovr", {24'd0, m_if.overrun_cnt}, 32'd0);

    // Encoding
    rst = 1'b0;
    m_if.enable = 1'b1;
    r = cyc;
    wait_start(2000, t);
    check("t1_latency", t - r, 1600);
    t0 = t;
    get_frame(got, 0, -1, 0);
    cmp_frame("f1", got, fr(72'hA5_04_19_03_21_80_32_48_C5));
    check("f1_seq", {27'd0, m_if.seq}, 32'd1);

    // Snapshot isolation: f_x changes during byte 3
    wait_start(400, t);
    check("f2_period", t - t0, 1600);
    get_frame(got, 1, 3, 0);
    cmp_frame("f2", got, fr(72'hA5_0C_19_03_21_80_32_48_CD));
    wait_start(400, t);
    get_frame(got, 0, -1, 0);
    cmp_frame("f3", got, fr(72'hA5_14_32_03_21_80_32_48_FE));
    check("f3_seq", {27'd0, m_if.seq}, 32'd3);

    // Reset mid-DATA of byte 4
    wait_start(400, t);
    repeat (696) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, m_if.tx}, 32'd1);
    check("mid_rst_busy", {31'd0, m_if.busy}, 32'd0);
    check("mid_rst_seq", {27'd0, m_if.seq}, 32'd0);
    check("mid_rst_done", {31'd0, m_if.frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    wait_start(2000, t);
    check("post_rst_latency", t - r, 1600);
    get_frame(got, 0, -1, 0);
    cmp_frame("f5", got, fr(72'hA5_04_32_03_21_80_32_48_EE));
    m_if.enable = 1'b0;
    check("main_ovr", {24'd0, m_if.overrun_cnt}, 32'd0);

    // Overrun, back-to-back frames, seq wrap
    sel = 1'b1;
    @(negedge clk);
    o_if.enable = 1'b1;
    r = cyc;
    wait_start(300, t);
    check("ov_latency", t - r, 100);
    for (int i = 0; i < 33; i++) begin
      get_frame(got, 0, -1, i == 0);
      x = got[1] ^ got[2] ^ got[3] ^ got[4] ^ got[5] ^ got[6] ^ got[7];
      check($sformatf("w%0d_sync", i), {24'd0, got[0]}, 32'hA5);
      check($sformatf("w%0d_seq", i), {27'd0, got[1][7:3]}, i % 32);
      check($sformatf("w%0d_state", i), {29'd0, got[1][2:0]}, 32'd4);
      check($sformatf("w%0d_csum", i), {24'd0, got[8]}, {24'd0, x});
      check($sformatf("w%0d_seq_out", i), {27'd0, l_seq}, (i + 1) % 32);
      @(negedge clk);
      check($sformatf("w%0d_b2b", i), {31'd0, ser}, 32'd0);
    end
    check("ovr_sat", {24'd0, o_if.overrun_cnt}, 32'd255);

    // Enable drop mid-frame with pending set
    get_frame(got, 2, 4, 0);
    x = got[1] ^ got[2] ^ got[3] ^ got[4] ^ got[5] ^ got[6] ^ got[7];
    check("ed_seq", {27'd0, got[1][7:3]}, 32'd1);
    check("ed_csum", {24'd0, got[8]}, {24'd0, x});
    check("ed_seq_out", {27'd0, l_seq}, 32'd2);
    idle_err = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ser !== 1'b1 || l_busy !== 1'b0) idle_err++;
    end
    check("ed_idle", idle_err, 0);
    o_if.enable = 1'b1;
    r = cyc;
    wait_start(300, t);
    check("ed_pending_cleared", t - r, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
